// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// ALU operation codes and datapath mux selects.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_REXEC  = 4'd6,
      S_RWB    = 4'd7,
      S_IEXEC  = 4'd8,
      S_IWB    = 4'd9,
      S_BEQEX  = 4'd10,
      S_BGTZEX = 4'd11,
      S_JEX    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LI    = 6'b011001;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_RTYP = 3'b010;
   localparam logic [2:0] ALU_XORI = 3'b011;
   localparam logic [2:0] ALU_LUI  = 3'b100;
   localparam logic [2:0] ALU_BGTZ = 3'b101;
   localparam logic [2:0] ALU_LI   = 3'b110;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS core: sequences fetch, decode,
// execute, memory and writeback, stalling on the memory ready handshake.
module mc_ctrl_fsm
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       memready,
   output logic       memread,
   output logic       memwrite,
   output logic       iord,
   output logic       irwrite,
   output logic       pcwrite,
   output logic       branch,
   output logic       branchgtz,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] aluop,
   output logic       illegal,
   output logic [3:0] state
);

   state_t state_q, state_d;
   // Remembers lw vs sw from DECODE so MEMADR does not look at op again.
   logic   is_sw_q, is_sw_d;

   logic mr_s, mw_s, irw_s, pcw_s, br_s, bg_s, rw_s, ill_s;

   // State register and load/store flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         is_sw_q <= 1'b0;
      end else begin
         state_q <= state_d;
         is_sw_q <= is_sw_d;
      end
   end

   // Next-state and Moore output decode.
   always_comb begin
      state_d  = S_FETCH;
      is_sw_d  = is_sw_q;
      mr_s     = 1'b0;
      mw_s     = 1'b0;
      irw_s    = 1'b0;
      pcw_s    = 1'b0;
      br_s     = 1'b0;
      bg_s     = 1'b0;
      rw_s     = 1'b0;
      ill_s    = 1'b0;
      iord     = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = SRCB_B;
      pcsrc    = PCSRC_ALU;
      aluop    = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            mr_s    = 1'b1;
            alusrcb = SRCB_FOUR;
            irw_s   = memready;
            pcw_s   = memready;
            state_d = memready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alusrcb = SRCB_IMM2;
            is_sw_d = (op == OP_SW);
            case (op)
               OP_LW, OP_SW:                      state_d = S_MEMADR;
               OP_RTYPE:                          state_d = S_REXEC;
               OP_BEQ:                            state_d = S_BEQEX;
               OP_BGTZ:                           state_d = S_BGTZEX;
               OP_ADDI, OP_XORI, OP_LUI, OP_LI:   state_d = S_IEXEC;
               OP_J:                              state_d = S_JEX;
               default: begin
                  state_d = S_FETCH;
                  ill_s   = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            state_d = is_sw_q ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mr_s    = 1'b1;
            iord    = 1'b1;
            state_d = memready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            rw_s     = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            mw_s    = 1'b1;
            iord    = 1'b1;
            state_d = memready ? S_FETCH : S_MEMWR;
         end
         S_REXEC: begin
            alusrca = 1'b1;
            aluop   = ALU_RTYP;
            state_d = S_RWB;
         end
         S_RWB: begin
            rw_s   = 1'b1;
            regdst = 1'b1;
         end
         S_IEXEC: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            case (op)
               OP_XORI: aluop = ALU_XORI;
               OP_LUI:  aluop = ALU_LUI;
               OP_LI:   aluop = ALU_LI;
               default: aluop = ALU_ADD;
            endcase
            state_d = S_IWB;
         end
         S_IWB: begin
            rw_s = 1'b1;
         end
         S_BEQEX: begin
            alusrca = 1'b1;
            aluop   = ALU_SUB;
            pcsrc   = PCSRC_ALUOUT;
            br_s    = 1'b1;
         end
         S_BGTZEX: begin
            alusrca = 1'b1;
            aluop   = ALU_BGTZ;
            pcsrc   = PCSRC_ALUOUT;
            bg_s    = 1'b1;
         end
         S_JEX: begin
            pcsrc = PCSRC_JUMP;
            pcw_s = 1'b1;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Reset suppresses every side effect on memory, PC, IR and register file.
   assign memread   = mr_s  & ~reset;
   assign memwrite  = mw_s  & ~reset;
   assign irwrite   = irw_s & ~reset;
   assign pcwrite   = pcw_s & ~reset;
   assign branch    = br_s  & ~reset;
   assign branchgtz = bg_s  & ~reset;
   assign regwrite  = rw_s  & ~reset;
   assign illegal   = ill_s & ~reset;
   assign state     = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle expected state/control snapshots
// are queued when inputs are driven and compared at the following falling edge.
module tb_mc_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'b100011;
   logic       memready = 1'b1;
   logic       memread, memwrite, iord, irwrite, pcwrite, branch, branchgtz;
   logic       regwrite, regdst, memtoreg, alusrca, illegal;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] aluop;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0]  st;
      logic [18:0] ctl;
   } exp_t;

   exp_t sb[$];

   localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                          MEMWB = 4'd4, MEMWR = 4'd5, REXEC = 4'd6, RWB = 4'd7,
                          IEXEC = 4'd8, IWB = 4'd9, BEQEX = 4'd10, BGTZEX = 4'd11,
                          JEX = 4'd12;

   mc_ctrl_fsm dut (
      .clk(clk), .reset(reset), .op(op), .memready(memready),
      .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
      .pcwrite(pcwrite), .branch(branch), .branchgtz(branchgtz),
      .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
      .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
      .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   // Control vector order: mr mw iord irw pcw br bg rw rd m2r asa asb pcs aop ill
   function automatic logic [18:0] mk(input logic mr, mw, io, irw, pcw, br, bg, rw, rd, m2r, asa,
                                      input logic [1:0] asb, pcs, input logic [2:0] aop,
                                      input logic ill);
      return {mr, mw, io, irw, pcw, br, bg, rw, rd, m2r, asa, asb, pcs, aop, ill};
   endfunction

   function automatic logic [18:0] c_iexec(input logic [2:0] aop);
      return mk(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, aop, 0);
   endfunction

   logic [18:0] C_FETCH_RDY, C_FETCH_WAIT, C_FETCH_RST, C_DECODE, C_ILL, C_MEMADR,
                C_MEMRD, C_MEMRD_RST, C_MEMWB, C_MEMWR, C_MEMWR_RST, C_REXEC, C_RWB,
                C_IWB, C_BEQ, C_BGTZ, C_JEX;

   task automatic cyc(input logic rs, input logic rdy, input logic [5:0] o,
                      input logic [3:0] est, input logic [18:0] ectl);
      exp_t e;
      exp_t got;
      reset = rs;
      memready = rdy;
      op = o;
      sb.push_back('{st: est, ctl: ectl});
      @(negedge clk);
      e = sb.pop_front();
      got.st  = state;
      got.ctl = {memread, memwrite, iord, irwrite, pcwrite, branch, branchgtz, regwrite,
                 regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal};
      checks++;
      assert (got.st === e.st) else begin
         errors++;
         $error("FAIL state t=%0t got %0d exp %0d", $time, got.st, e.st);
      end
      checks++;
      assert (got.ctl === e.ctl) else begin
         errors++;
         $error("FAIL ctl st=%0d t=%0t got %b exp %b", e.st, $time, got.ctl, e.ctl);
      end
      @(posedge clk);
      #1;
   endtask

   logic [5:0]  iops [4];
   logic [2:0]  iaop [4];

   initial begin
      C_FETCH_RDY  = mk(1,0,0,1,1,0,0,0,0,0,0, 2'b01, 2'b00, 3'b000, 0);
      C_FETCH_WAIT = mk(1,0,0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b000, 0);
      C_FETCH_RST  = mk(0,0,0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b000, 0);
      C_DECODE     = mk(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b000, 0);
      C_ILL        = mk(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b000, 1);
      C_MEMADR     = mk(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b000, 0);
      C_MEMRD      = mk(1,0,1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
      C_MEMRD_RST  = mk(0,0,1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
      C_MEMWB      = mk(0,0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b000, 0);
      C_MEMWR      = mk(0,1,1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
      C_MEMWR_RST  = mk(0,0,1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
      C_REXEC      = mk(0,0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b010, 0);
      C_RWB        = mk(0,0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 3'b000, 0);
      C_IWB        = mk(0,0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b000, 0);
      C_BEQ        = mk(0,0,0,0,0,1,0,0,0,0,1, 2'b00, 2'b01, 3'b001, 0);
      C_BGTZ       = mk(0,0,0,0,0,0,1,0,0,0,1, 2'b00, 2'b01, 3'b101, 0);
      C_JEX        = mk(0,0,0,0,1,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 0);
      iops[0] = 6'b001110; iaop[0] = 3'b011;
      iops[1] = 6'b001111; iaop[1] = 3'b100;
      iops[2] = 6'b011001; iaop[2] = 3'b110;
      iops[3] = 6'b001000; iaop[3] = 3'b000;

      // Reset two cycles with lw/memready high; first edge establishes FETCH.
      @(posedge clk); #1;
      cyc(1, 1, 6'b100011, FETCH, C_FETCH_RST);

      // lw, memready high: 5 cycles.
      cyc(0, 1, 6'b100011, FETCH,  C_FETCH_RDY);
      cyc(0, 1, 6'b100011, DECODE, C_DECODE);
      cyc(0, 1, 6'b100011, MEMADR, C_MEMADR);
      cyc(0, 1, 6'b100011, MEMRD,  C_MEMRD);
      cyc(0, 1, 6'b100011, MEMWB,  C_MEMWB);

      // sw with fetch wait and 3 stall cycles in MEMWR.
      cyc(0, 0, 6'b101011, FETCH,  C_FETCH_WAIT);
      cyc(0, 1, 6'b101011, FETCH,  C_FETCH_RDY);
      cyc(0, 1, 6'b101011, DECODE, C_DECODE);
      cyc(0, 1, 6'b101011, MEMADR, C_MEMADR);
      cyc(0, 0, 6'b101011, MEMWR,  C_MEMWR);
      cyc(0, 0, 6'b101011, MEMWR,  C_MEMWR);
      cyc(0, 0, 6'b101011, MEMWR,  C_MEMWR);
      cyc(0, 1, 6'b101011, MEMWR,  C_MEMWR);

      // I-type ALU ops.
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, iops[i], FETCH,  C_FETCH_RDY);
         cyc(0, 1, iops[i], DECODE, C_DECODE);
         cyc(0, 1, iops[i], IEXEC,  c_iexec(iaop[i]));
         cyc(0, 1, iops[i], IWB,    C_IWB);
      end

      // R-type.
      cyc(0, 1, 6'b000000, FETCH,  C_FETCH_RDY);
      cyc(0, 1, 6'b000000, DECODE, C_DECODE);
      cyc(0, 1, 6'b000000, REXEC,  C_REXEC);
      cyc(0, 1, 6'b000000, RWB,    C_RWB);

      // bgtz, beq, j: 3 cycles each.
      cyc(0, 1, 6'b000111, FETCH,  C_FETCH_RDY);
      cyc(0, 1, 6'b000111, DECODE, C_DECODE);
      cyc(0, 1, 6'b000111, BGTZEX, C_BGTZ);
      cyc(0, 1, 6'b000100, FETCH,  C_FETCH_RDY);
      cyc(0, 1, 6'b000100, DECODE, C_DECODE);
      cyc(0, 1, 6'b000100, BEQEX,  C_BEQ);
      cyc(0, 1, 6'b000010, FETCH,  C_FETCH_RDY);
      cyc(0, 1, 6'b000010, DECODE, C_DECODE);
      cyc(0, 1, 6'b000010, JEX,    C_JEX);

      // Unknown opcode.
      cyc(0, 1, 6'b111111, FETCH,  C_FETCH_RDY);
      cyc(0, 1, 6'b111111, DECODE, C_ILL);

      // Reset during a MEMRD stall.
      cyc(0, 1, 6'b100011, FETCH,  C_FETCH_RDY);
      cyc(0, 1, 6'b100011, DECODE, C_DECODE);
      cyc(0, 1, 6'b100011, MEMADR, C_MEMADR);
      cyc(0, 0, 6'b100011, MEMRD,  C_MEMRD);
      cyc(1, 1, 6'b100011, MEMRD,  C_MEMRD_RST);

      // Reset during a MEMWR stall.
      cyc(0, 1, 6'b101011, FETCH,  C_FETCH_RDY);
      cyc(0, 1, 6'b101011, DECODE, C_DECODE);
      cyc(0, 1, 6'b101011, MEMADR, C_MEMADR);
      cyc(0, 0, 6'b101011, MEMWR,  C_MEMWR);
      cyc(1, 1, 6'b101011, MEMWR,  C_MEMWR_RST);
      cyc(0, 0, 6'b101011, FETCH,  C_FETCH_WAIT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Main control state machine for the multicycle MIPS core. It sequences the shared datapath (one memory port, one ALU, register file) across fetch, decode, execute, memory and writeback cycles, and stalls on a memory ready handshake. It drives `aluop[2:0]` into the existing ALU decoder, which produces `alucontrol`/`runxor` from `aluop` and `funct`.

## Interface
No parameters; all encodings are fixed in `mc_pkg`.
- `clk` in 1 — system clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `op` in 6 — opcode from the instruction register.
- `memready` in 1 — memory has completed the current read or write this cycle.
- `memread` out 1 — memory read request (fetch or lw).
- `memwrite` out 1 — memory write request (sw).
- `iord` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `irwrite` out 1 — load the instruction register.
- `pcwrite` out 1 — unconditional PC write.
- `branch` out 1 — PC write qualified by ALU zero (beq).
- `branchgtz` out 1 — PC write qualified by (result > 0) (bgtz).
- `regwrite` out 1 — register file write.
- `regdst` out 1 — write register select: 1 = rd, 0 = rt.
- `memtoreg` out 1 — writeback source: 1 = Data register, 0 = ALUOut.
- `alusrca` out 1 — ALU A select: 0 = PC, 1 = A.
- `alusrcb` out 2 — ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc` out 2 — PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `aluop` out 3 — 000 add, 001 sub, 010 R-type (use funct), 011 xori, 100 lui, 101 bgtz, 110 li.
- `illegal` out 1 — one-cycle pulse on an unknown opcode.
- `state` out 4 — current state, for debug.

## Operation

**Opcodes**
- R 000000, lw 100011, sw 101011, beq 000100, bgtz 000111, addi 001000, xori 001110, lui 001111, li 011001, j 000010.

**States and control outputs.** Every output not listed for a state is 0.
- FETCH
  - Outputs: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=000, pcsrc=00.
  - irwrite and pcwrite equal `memready`.
  - Stays in FETCH while `memready`=0; goes to DECODE when `memready`=1.
- DECODE
  - Outputs: alusrca=0, alusrcb=11, aluop=000 (branch target into ALUOut).
  - Next state by `op`:
    - lw or sw → MEMADR
    - R → REXEC
    - beq → BEQEX
    - bgtz → BGTZEX
    - addi, xori, lui, li → IEXEC
    - j → JEX
    - any other opcode → FETCH, with `illegal`=1 for this cycle.
- MEMADR
  - Outputs: alusrca=1, alusrcb=10, aluop=000.
  - lw → MEMRD; sw → MEMWR.
- MEMRD
  - Outputs: memread=1, iord=1.
  - Holds until `memready`=1, then → MEMWB.
- MEMWB
  - Outputs: regwrite=1, regdst=0, memtoreg=1.
  - → FETCH.
- MEMWR
  - Outputs: memwrite=1, iord=1.
  - Holds until `memready`=1, then → FETCH.
- REXEC
  - Outputs: alusrca=1, alusrcb=00, aluop=010.
  - → RWB.
- RWB
  - Outputs: regwrite=1, regdst=1, memtoreg=0.
  - → FETCH.
- IEXEC
  - Outputs: alusrca=1, alusrcb=10.
  - aluop by `op`: addi 000, xori 011, lui 100, li 110.
  - → IWB.
- IWB
  - Outputs: regwrite=1, regdst=0, memtoreg=0.
  - → FETCH.
- BEQEX
  - Outputs: alusrca=1, alusrcb=00, aluop=001, pcsrc=01, branch=1.
  - → FETCH.
- BGTZEX
  - Outputs: alusrca=1, alusrcb=00, aluop=101, pcsrc=01, branchgtz=1.
  - → FETCH.
- JEX
  - Outputs: pcsrc=10, pcwrite=1.
  - → FETCH.

**Rules**
- `op` is sampled in DECODE and IEXEC only.
- The instruction register holds `op` stable from the FETCH completion until the next FETCH completion.
- The state register uses a 4-bit encoding (13 states).
- Any unreachable state code → FETCH on the next edge, with all enables 0.

## Timing
- Reset
  - While `reset`=1, every write enable, memread and illegal are forced to 0.
  - On the first edge with `reset` high, state becomes FETCH.
  - After reset is released, state=FETCH and outputs are the FETCH values.
- Reset asserted mid-instruction (including during a MEMWR stall): no further write enable is asserted, and the FSM returns to FETCH after one edge.
- Outputs are Moore (a function of state only). Exceptions: irwrite, pcwrite in FETCH, and `illegal` in DECODE are combinational on `memready`/`op`.
- Instruction latency with `memready` tied high:
  - beq, bgtz, j: 3 cycles
  - R-type, I-type ALU, sw: 4 cycles
  - lw: 5 cycles
- Each wait cycle adds 1 cycle, in FETCH, MEMRD or MEMWR.
- Memory handshake
  - memread/memwrite stay asserted and iord stays stable for every stall cycle.
  - The transaction completes on the cycle with `memready`=1.
  - `memready` is ignored in all other states.

## Structure
- `mc_pkg` contains:
  - the `state_t` enum;
  - opcode localparams;
  - aluop localparams (shared with the ALU decoder);
  - alusrcb and pcsrc encodings.
- Single module with two always blocks: a sequential state register and a combinational next-state/output decode. No sub-module; the ALU decoder stays a separate sibling instantiated by the controller wrapper.

## Test plan
1. Reset for 2 cycles with op=100011 and memready=1 → no write enable during reset; state=FETCH after release.
2. lw, memready always 1:
   - state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB;
   - regwrite=1 with memtoreg=1 in cycle 5 only.
3. sw, memready low for 3 cycles in MEMWR → memwrite=1 and iord=1 held for 4 cycles, then FETCH.
4. I-type aluop:
   - op=001110 → aluop=011 in IEXEC, regwrite with regdst=0 in IWB;
   - repeat for lui (100), li (110) and addi (000).
5. bgtz → BGTZEX: branchgtz=1, aluop=101, pcsrc=01; back in FETCH at cycle 4.
6. Unknown opcode:
   - op=111111 → illegal pulses in DECODE, next state FETCH, no write enable.
   - Separately, reset asserted during MEMRD → FETCH next cycle and regwrite never asserted.
